// File: rtl/uart_buffer_pkg.sv
// Shared definitions for the UART byte buffer: CPU and UART register
// addresses, sequencer states and a small status-word helper.
package uart_buffer_pkg;

    // CPU-side word addresses
    localparam logic [2:0] UB_DATA   = 3'd0;
    localparam logic [2:0] UB_STAT   = 3'd1;
    localparam logic [2:0] UB_TXDONE = 3'd2;
    localparam logic [2:0] UB_CTRL   = 3'd3;
    localparam logic [2:0] UB_IRQEN  = 3'd4;

    // UART core register addresses
    localparam logic [2:0] U_DATA   = 3'd0;
    localparam logic [2:0] U_RXSTAT = 3'd1;
    localparam logic [2:0] U_TXSTAT = 3'd2;

    // Round-robin sequencer, one UART register access per state
    typedef enum logic [2:0] {
        ST_POLL_RX,
        ST_READ_RX,
        ST_CLR_RX,
        ST_POLL_TX,
        ST_SEND,
        ST_SETTLE
    } seq_state_t;

    // Single-bit status flags live in bit 24 of a register word
    function automatic logic [31:0] flag_word(input logic f);
        return {7'b0, f, 24'b0};
    endfunction

endpackage

// File: rtl/uart_buffer_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop support. Full and empty
// are derived from the count at the start of the cycle, so a push into a
// full FIFO is dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_buffer.sv
// CPU-facing TX/RX byte buffer that masters the UART register port.
// A round-robin sequencer polls UART status, feeds queued TX bytes to the
// UART and moves received bytes into the RX FIFO.
module uart_buffer
    import uart_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq,
    output logic [2:0]  u_a,
    output logic [31:0] u_d,
    output logic        u_we,
    input  logic [31:0] u_spo
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t      state;
    seq_state_t      state_next;

    logic            tx_push;
    logic            tx_pop;
    logic            tx_full;
    logic            tx_empty;
    logic [7:0]      tx_head;
    logic [CW-1:0]   tx_count;

    logic            rx_push;
    logic            rx_pop;
    logic            rx_full;
    logic            rx_empty;
    logic [7:0]      rx_head;
    logic [CW-1:0]   rx_count;

    logic            tx_ovf;
    logic            rx_ovf;
    logic            irq_en;
    logic            last_idle;
    logic            tx_all_done;
    logic            ctrl_wr;
    logic [7:0]      tx_cnt8;
    logic [7:0]      rx_cnt8;
    logic            unused_bits;

    assign unused_bits = ^{d[23:10], d[7:0], u_spo[23:0]};

    assign tx_push = we && (a == UB_DATA);
    assign tx_pop  = (state == ST_SEND);
    assign rx_push = (state == ST_READ_RX);
    assign rx_pop  = we && (a == UB_STAT);
    assign ctrl_wr = we && (a == UB_CTRL);

    assign tx_cnt8 = 8'(tx_count);
    assign rx_cnt8 = 8'(rx_count);

    assign tx_all_done = tx_empty && (state != ST_SEND) &&
                         (state != ST_SETTLE) && last_idle;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (d[31:24]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (u_spo[31:24]),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky overflow flags; a new overflow beats a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_push && tx_full) begin
                tx_ovf <= 1'b1;
            end else if (ctrl_wr && d[8]) begin
                tx_ovf <= 1'b0;
            end
            if (rx_push && rx_full) begin
                rx_ovf <= 1'b1;
            end else if (ctrl_wr && d[9]) begin
                rx_ovf <= 1'b0;
            end
        end
    end

    // Interrupt enable register and registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (we && (a == UB_IRQEN)) begin
                irq_en <= d[24];
            end
            irq <= irq_en && !rx_empty;
        end
    end

    // Remember the last TX idle poll; a send makes the UART busy again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idle <= 1'b0;
        end else if (state == ST_POLL_TX) begin
            last_idle <= u_spo[24];
        end else if (state == ST_SEND) begin
            last_idle <= 1'b0;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_POLL_RX;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next-state: alternate RX and TX service each round
    always_comb begin
        state_next = state;
        case (state)
            ST_POLL_RX: state_next = u_spo[24] ? ST_READ_RX : ST_POLL_TX;
            ST_READ_RX: state_next = ST_CLR_RX;
            ST_CLR_RX:  state_next = ST_POLL_TX;
            ST_POLL_TX: state_next = (u_spo[24] && !tx_empty) ? ST_SEND : ST_POLL_RX;
            ST_SEND:    state_next = ST_SETTLE;
            ST_SETTLE:  state_next = ST_POLL_RX;
            default:    state_next = ST_POLL_RX;
        endcase
    end

    // UART bus outputs decoded from state; write data only driven in SEND
    always_comb begin
        u_a  = U_RXSTAT;
        u_we = 1'b0;
        u_d  = 32'h0;
        case (state)
            ST_POLL_RX: u_a = U_RXSTAT;
            ST_READ_RX: u_a = U_DATA;
            ST_CLR_RX: begin
                u_a  = U_RXSTAT;
                u_we = 1'b1;
            end
            ST_POLL_TX: u_a = U_TXSTAT;
            ST_SEND: begin
                u_a  = U_DATA;
                u_we = 1'b1;
                u_d  = {tx_head, 24'b0};
            end
            ST_SETTLE:  u_a = U_TXSTAT;
            default:    u_a = U_RXSTAT;
        endcase
    end

    // CPU read mux, combinational on the address
    always_comb begin
        spo = 32'h0;
        case (a)
            UB_DATA:   spo = rx_empty ? 32'h0 : {rx_head, 24'b0};
            UB_STAT:   spo = flag_word(!rx_empty);
            UB_TXDONE: spo = flag_word(tx_all_done);
            UB_CTRL:   spo = {rx_cnt8, tx_cnt8, 6'b0, rx_ovf, tx_ovf, 8'b0};
            UB_IRQEN:  spo = flag_word(irq_en);
            default:   spo = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_uart_buffer.sv
// Self-checking bench for uart_buffer with a behavioural UART register
// model and queue-based expectations for both FIFOs.
module tb_uart_buffer;

    localparam int DEPTH       = 16;
    localparam int BUSY_CYCLES = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        irq;
    logic [2:0]  u_a;
    logic [31:0] u_d;
    logic        u_we;
    logic [31:0] u_spo;

    int checks = 0;
    int errors = 0;

    uart_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .d     (d),
        .we    (we),
        .spo   (spo),
        .irq   (irq),
        .u_a   (u_a),
        .u_d   (u_d),
        .u_we  (u_we),
        .u_spo (u_spo)
    );

    always #5 clk = ~clk;

    // UART register model
    int         busy;
    logic       hold_busy;
    logic       rx_new;
    logic [7:0] rx_byte;
    logic       inject_req;
    logic [7:0] inject_byte;
    logic       tx_idle;

    assign tx_idle = (busy == 0) && !hold_busy;

    always_comb begin
        u_spo = 32'h0;
        case (u_a)
            3'd0:    u_spo = {rx_byte, 24'b0};
            3'd1:    u_spo = {7'b0, rx_new, 24'b0};
            3'd2:    u_spo = {7'b0, tx_idle, 24'b0};
            default: u_spo = 32'h0;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 0;
            rx_new  <= 1'b0;
            rx_byte <= 8'h0;
        end else begin
            if (u_we && u_a == 3'd0) busy <= BUSY_CYCLES;
            else if (busy > 0)       busy <= busy - 1;
            if (inject_req) begin
                rx_new  <= 1'b1;
                rx_byte <= inject_byte;
            end else if (u_we && u_a == 3'd1) begin
                rx_new <= 1'b0;
            end
        end
    end

    // Bus monitor: records bytes the UART accepted and access statistics
    logic [7:0] sent_q [$];
    int rx_reads  = 0;
    int rx_clears = 0;
    int illegal   = 0;

    always @(posedge clk) begin
        if (u_we && u_a == 3'd0) sent_q.push_back(u_d[31:24]);
        if (!u_we && u_a == 3'd0) rx_reads++;
        if (u_we && u_a == 3'd1) rx_clears++;
        if (u_we && u_a != 3'd0 && u_a != 3'd1) illegal++;
        if (!u_we && u_d != 32'h0) illegal++;
    end

    // Reference model state
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];
    int         sent_base;
    logic       m_tx_ovf;
    logic       m_rx_ovf;

    function automatic int tx_level();
        return exp_tx.size() - (sent_q.size() - sent_base);
    endfunction

    function automatic logic [31:0] exp_stat();
        int rc;
        int tc;
        rc = exp_rx.size();
        tc = tx_level();
        return {rc[7:0], tc[7:0], 6'b0, m_rx_ovf, m_tx_ovf, 8'b0};
    endfunction

    task automatic cpu_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        a = addr; d = data; we = 1'b1;
        @(negedge clk);
        we = 1'b0; d = 32'h0;
    endtask

    task automatic cpu_read(input logic [2:0] addr, output logic [31:0] data);
        a = addr;
        #1;
        data = spo;
    endtask

    // Push decision uses the occupancy at the start of the write cycle
    task automatic cpu_push(input logic [7:0] b);
        @(negedge clk);
        if (tx_level() < DEPTH) exp_tx.push_back(b);
        else                    m_tx_ovf = 1'b1;
        a = 3'd0; d = {b, 24'b0}; we = 1'b1;
        @(negedge clk);
        we = 1'b0; d = 32'h0;
    endtask

    task automatic inject_start(input logic [7:0] b);
        @(negedge clk);
        inject_byte = b; inject_req = 1'b1;
        @(negedge clk);
        inject_req = 1'b0;
    endtask

    task automatic wait_pickup(input logic [7:0] b);
        for (int i = 0; i < 40 && rx_new; i++) @(negedge clk);
        checks++;
        if (rx_new !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_pickup_timeout got rx_new=%b exp 0", rx_new);
        end
        if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
        else                       m_rx_ovf = 1'b1;
    endtask

    task automatic find_send(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_we === 1'b1 && u_a === 3'd0) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_drain();
        logic [31:0] r;
        for (int i = 0; i < 3000 && (sent_q.size() - sent_base) < exp_tx.size(); i++)
            @(negedge clk);
        repeat (60) @(negedge clk);
        checks++;
        if ((sent_q.size() - sent_base) != exp_tx.size()) begin
            errors++;
            $display("[TB] FAIL tx_sent_count got %0d exp %0d", sent_q.size() - sent_base, exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && (sent_base + i) < sent_q.size(); i++) begin
            checks++;
            if (sent_q[sent_base + i] !== exp_tx[i]) begin
                errors++;
                $display("[TB] FAIL tx_byte[%0d] got %h exp %h", i, sent_q[sent_base + i], exp_tx[i]);
            end
        end
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat()) begin
            errors++;
            $display("[TB] FAIL stat_after_drain got %h exp %h", r, exp_stat());
        end
    endtask

    task automatic pop_all_rx();
        logic [31:0] r;
        while (exp_rx.size() > 0) begin
            cpu_read(3'd0, r);
            checks++;
            if (r !== {exp_rx[0], 24'b0}) begin
                errors++;
                $display("[TB] FAIL rx_head got %h exp %h", r, {exp_rx[0], 24'b0});
            end
            cpu_write(3'd1, 32'h0);
            void'(exp_rx.pop_front());
        end
        cpu_read(3'd1, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rx_empty_after_pops got %h exp 0", r);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            cpu_read(3'(i), r);
            checks++;
            if (r !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_spo a=%0d got %h exp 0", i, r);
            end
        end
        checks++;
        if (u_a !== 3'd1 || u_we !== 1'b0 || u_d !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got u_a=%0d u_we=%b u_d=%h irq=%b exp 1 0 0 0", u_a, u_we, u_d, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tx_drain();
        logic [31:0] r;
        int n;
        cpu_push(8'h41); cpu_push(8'h42); cpu_push(8'h43);
        for (int i = 0; i < 500 && (sent_q.size() - sent_base) < 3; i++) @(negedge clk);
        cpu_read(3'd2, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("[TB] FAIL tx_done_early got %h exp 0", r);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cpu_read(3'd2, r);
            if (r[24]) break;
        end
        checks++;
        if (r !== 32'h0100_0000) begin
            errors++;
            $display("[TB] FAIL tx_done_timeout got %h exp 01000000", r);
        end
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("[TB] FAIL tx_done_while_busy got busy=%0d exp 0", busy);
        end
        wait_drain();
        n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) cpu_push(8'($urandom));
        wait_drain();
    endtask

    task automatic test_rx_receive();
        logic [31:0] r;
        int r0;
        int c0;
        cpu_write(3'd4, 32'h0100_0000);
        cpu_read(3'd4, r);
        checks++;
        if (r !== 32'h0100_0000) begin
            errors++;
            $display("[TB] FAIL irq_en_read got %h exp 01000000", r);
        end
        r0 = rx_reads; c0 = rx_clears;
        inject_start(8'h5A);
        for (int i = 0; i < 40; i++) begin
            cpu_read(3'd1, r);
            if (r[24]) break;
            @(negedge clk);
        end
        checks++;
        if (r !== 32'h0100_0000 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_nonempty_first got %h irq=%b exp 01000000 irq=0", r, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_rise got %b exp 1", irq);
        end
        wait_pickup(8'h5A);
        checks++;
        if (rx_reads - r0 != 1 || rx_clears - c0 != 1) begin
            errors++;
            $display("[TB] FAIL rx_access got reads=%0d clears=%0d exp 1 1", rx_reads - r0, rx_clears - c0);
        end
        cpu_read(3'd0, r);
        checks++;
        if (r !== 32'h5A00_0000) begin
            errors++;
            $display("[TB] FAIL rx_data got %h exp 5a000000", r);
        end
        cpu_write(3'd1, 32'h0);
        void'(exp_rx.pop_front());
        cpu_read(3'd1, r);
        checks++;
        if (r !== 32'h0 || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rx_pop got %h irq=%b exp 0 irq=1", r, irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_fall got %b exp 0", irq);
        end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            inject_start(b);
            wait_pickup(b);
        end
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat()) begin
            errors++;
            $display("[TB] FAIL rx_stat got %h exp %h", r, exp_stat());
        end
        pop_all_rx();
    endtask

    task automatic test_tx_overflow();
        logic [31:0] r;
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH + 1; i++) cpu_push(8'($urandom));
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat() || r[23:16] !== 8'd16 || r[8] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_ovf_stat got %h exp %h", r, exp_stat());
        end
        cpu_write(3'd3, 32'h0000_0100);
        m_tx_ovf = 1'b0;
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat()) begin
            errors++;
            $display("[TB] FAIL tx_ovf_clear got %h exp %h", r, exp_stat());
        end
        hold_busy = 1'b0;
        wait_drain();
    endtask

    task automatic test_rx_overflow();
        logic [31:0] r;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            inject_start(b);
            wait_pickup(b);
        end
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat() || r[31:24] !== 8'd16 || r[9] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rx_ovf_stat got %h exp %h", r, exp_stat());
        end
        cpu_write(3'd3, 32'h0000_0200);
        m_rx_ovf = 1'b0;
        pop_all_rx();
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat()) begin
            errors++;
            $display("[TB] FAIL rx_ovf_clear got %h exp %h", r, exp_stat());
        end
    endtask

    // CPU push lands in the same cycle as a sequencer SEND pop
    task automatic push_during_send();
        bit found;
        logic [7:0] b;
        find_send(found);
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL send_timeout got none exp SEND");
        end
        b = 8'($urandom);
        if (tx_level() < DEPTH) exp_tx.push_back(b);
        else                    m_tx_ovf = 1'b1;
        a = 3'd0; d = {b, 24'b0}; we = 1'b1; hold_busy = 1'b1;
        @(negedge clk);
        we = 1'b0; d = 32'h0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH - 1; i++) cpu_push(8'($urandom));
        hold_busy = 1'b0;
        push_during_send();
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat() || r[23:16] !== 8'd15) begin
            errors++;
            $display("[TB] FAIL simul_15 got %h exp %h", r, exp_stat());
        end
        cpu_push(8'($urandom));
        hold_busy = 1'b0;
        push_during_send();
        cpu_read(3'd3, r);
        checks++;
        if (r !== exp_stat() || r[23:16] !== 8'd15 || r[8] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_full got %h exp %h", r, exp_stat());
        end
        cpu_write(3'd3, 32'h0000_0100);
        m_tx_ovf = 1'b0;
        hold_busy = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid_send();
        logic [31:0] r;
        bit found;
        hold_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) cpu_push(8'($urandom));
        hold_busy = 1'b0;
        find_send(found);
        a = 3'd3;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!found || u_we !== 1'b0 || u_a !== 3'd1 || u_d !== 32'h0 || irq !== 1'b0 || spo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset got found=%b u_we=%b u_a=%0d u_d=%h irq=%b spo=%h exp 1 0 1 0 0 0",
                     found, u_we, u_a, u_d, irq, spo);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_tx.delete(); exp_rx.delete();
        sent_base = sent_q.size();
        m_tx_ovf = 1'b0; m_rx_ovf = 1'b0;
        cpu_read(3'd3, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("[TB] FAIL counts_after_reset got %h exp 0", r);
        end
        cpu_read(3'd4, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("[TB] FAIL irq_en_after_reset got %h exp 0", r);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (sent_q.size() != sent_base) begin
            errors++;
            $display("[TB] FAIL send_after_reset got %0d exp 0", sent_q.size() - sent_base);
        end
    endtask

    task automatic test_random_traffic();
        for (int round = 0; round < 6; round++) begin
            logic [7:0] b;
            int n;
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) cpu_push(8'($urandom));
            b = 8'($urandom);
            inject_start(b);
            wait_pickup(b);
        end
        wait_drain();
        pop_all_rx();
        checks++;
        if (illegal != 0) begin
            errors++;
            $display("[TB] FAIL uart_bus_protocol got %0d bad accesses exp 0", illegal);
        end
    endtask

    initial begin
        rst_n = 1'b0; a = 3'd0; d = 32'h0; we = 1'b0;
        hold_busy = 1'b0; inject_req = 1'b0; inject_byte = 8'h0;
        sent_base = 0; m_tx_ovf = 1'b0; m_rx_ovf = 1'b0;
        #12;
        test_reset();
        test_tx_drain();
        test_rx_receive();
        test_tx_overflow();
        test_rx_overflow();
        test_back_to_back();
        test_reset_mid_send();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
